sap_microsequencer: RTL and testbench
=====================================

Name: sap_microsequencer

Overview:
Parametrised successor to the fixed 6-stage SAP-1 controller. Decodes a 4-bit opcode into a 16-bit control word per T-state. Adds variable-length instructions, conditional jumps on carry/zero flags, a sticky halt, and run/single-step gating. Sits between the instruction register and the datapath. Advances on the falling clock edge, so the control word is stable at every rising edge the datapath uses.

Parameters:
VARIABLE_LEN, 1, 1: instruction ends after its last active stage; 0: every instruction runs all 6 stages, T0..T5 (legacy timing).
STEP_EN, 1, 1: `run`/`step` gate stage advance; 0: `run`/`step` are ignored and the block always free-runs.

Ports:
clk  input  1  system clock; stage state updates on the negedge.
rst  input  1  reset, asynchronous, active-high.
opcode  input  4  IR upper nibble, valid from T2 onward.
carry  input  1  datapath carry flag, sampled combinationally in T3.
zero  input  1  datapath zero flag, sampled combinationally in T3.
run  input  1  1 = free-run; 0 = advance only on `step` rising edge.
step  input  1  single-step request, level input.
out  output  16  control word.
stage  output  3  current T-state, 0..5.
halted  output  1  sticky halt indicator.
instr_end  output  1  high during the last stage of the current instruction.

Behaviour:
- Control word bits: 15 HLT, 14 PC_INC, 13 PC_EN, 12 PC_LOAD, 11 MEM_LOAD, 10 MEM_EN, 9 IR_LOAD, 8 IR_EN, 7 A_LOAD, 6 A_EN, 5 B_LOAD, 4 ALU_SUB, 3 ALU_EN, 2 OUT_LOAD, 1 FLAGS_LOAD, 0 RAM_WE.
- `out` is combinational from (stage, opcode, carry, zero, halted). All bits not listed below are 0.
- Fetch stages, all opcodes:
  - T0: PC_EN, MEM_LOAD (0x2800).
  - T1: MEM_EN, IR_LOAD (0x0600).
  - T2: PC_INC (0x4000).
- Execute stages:
  - LDA 0000: T3 IR_EN, MEM_LOAD; T4 MEM_EN, A_LOAD. Last stage T4.
  - ADD 0001: T3 IR_EN, MEM_LOAD; T4 MEM_EN, B_LOAD; T5 ALU_EN, A_LOAD, FLAGS_LOAD. Last stage T5.
  - SUB 0010: as ADD, plus ALU_SUB in T5.
  - STA 0011: T3 IR_EN, MEM_LOAD; T4 A_EN, RAM_WE. Last stage T4.
  - LDI 0100: T3 IR_EN, A_LOAD. Last stage T3.
  - JMP 0101: T3 IR_EN, PC_LOAD. Last stage T3.
  - JC 0110: T3 IR_EN always; PC_LOAD only if carry=1. Last stage T3.
  - JZ 0111: as JC, using zero.
  - OUT 1110: T3 A_EN, OUT_LOAD. Last stage T3.
  - HLT 1111: T3 HLT. Last stage T3.
  - All other opcodes: NOP, last stage T2.
- Advance enable `adv`:
  - STEP_EN=0: adv=1.
  - STEP_EN=1: adv = run | (step & ~step_q). step_q is `step` registered on the negedge, reset 0.
- Stage update, on negedge when adv=1 and halted=0:
  - VARIABLE_LEN=1: if stage is the last stage of the opcode, stage<=0; else stage+1.
  - VARIABLE_LEN=0: stage 5 -> 0, else stage+1; stages past the last active stage output 0x0000.
- `instr_end`:
  - VARIABLE_LEN=1: high in the opcode's last stage.
  - VARIABLE_LEN=0: high in T5.
- Halt:
  - On the negedge leaving T3 of HLT (adv=1), halted<=1 and stage holds at 3.
  - While halted=1: out=0x8000, stage frozen, run/step ignored.
  - Only rst clears halted.
- `step` held high produces exactly one advance. Re-arming requires `step` to be low at one negedge.
- Simultaneous run=1 and a step edge: single advance, no double step.
- Opcode change mid-instruction: out follows the current opcode combinationally. The datapath guarantees a stable IR from T2 on; the block does not latch the opcode.
- Reset, any time including mid-instruction:
  - stage=0, halted=0, step_q=0.
  - out=0x2800, instr_end=0.
  - Effect is immediate (asynchronous); normal sequencing resumes on the first negedge after rst falls.

Test Plan:
1. Reset assertion mid-ADD at T4 -> stage=0, out=0x2800, halted=0 immediately, before any clock edge.
2. VARIABLE_LEN=1, opcode=LDA, run=1 -> out per stage 0x2800, 0x0600, 0x4000, 0x0900, 0x0480, then stage wraps to 0 after 5 negedges; instr_end=1 only in T4.
3. JC in T3 with carry=0 -> out=0x0100; with carry=1 -> 0x1100. JZ with zero=1 -> 0x1100. After T3, stage returns to 0.
4. opcode=HLT -> T3 out=0x8000; after the next negedge halted=1, stage=3, out=0x8000 for 10 further clocks with run=1 and step toggling; rst then gives stage=0, halted=0.
5. STEP_EN=1, run=0, step held high 5 clocks -> stage advances exactly once (0->1); step low 1 clock then high -> one more advance (1->2).
6. VARIABLE_LEN=0, opcode=LDI -> 6 stages per instruction; T3 out=0x0180, T4 and T5 out=0x0000, instr_end only in T5; opcode=1010 (NOP) also takes 6 stages.

Source files
------------

// File: rtl/sap_microsequencer.sv
// SAP-1 style microsequencer: decodes the IR opcode into a 16-bit control word per T-state,
// stepping on the falling edge so the word is settled before each datapath rising edge.
module sap_microsequencer #(
  parameter bit VARIABLE_LEN = 1'b1,
  parameter bit STEP_EN      = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  opcode,
  input  logic        carry,
  input  logic        zero,
  input  logic        run,
  input  logic        step,
  output logic [15:0] out,
  output logic [2:0]  stage,
  output logic        halted,
  output logic        instr_end
);

  localparam logic [2:0] T0 = 3'd0;
  localparam logic [2:0] T1 = 3'd1;
  localparam logic [2:0] T2 = 3'd2;
  localparam logic [2:0] T3 = 3'd3;
  localparam logic [2:0] T4 = 3'd4;
  localparam logic [2:0] T5 = 3'd5;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_STA = 4'b0011;
  localparam logic [3:0] OP_LDI = 4'b0100;
  localparam logic [3:0] OP_JMP = 4'b0101;
  localparam logic [3:0] OP_JC  = 4'b0110;
  localparam logic [3:0] OP_JZ  = 4'b0111;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [15:0] HLT        = 16'h8000;
  localparam logic [15:0] PC_INC     = 16'h4000;
  localparam logic [15:0] PC_EN      = 16'h2000;
  localparam logic [15:0] PC_LOAD    = 16'h1000;
  localparam logic [15:0] MEM_LOAD   = 16'h0800;
  localparam logic [15:0] MEM_EN     = 16'h0400;
  localparam logic [15:0] IR_LOAD    = 16'h0200;
  localparam logic [15:0] IR_EN      = 16'h0100;
  localparam logic [15:0] A_LOAD     = 16'h0080;
  localparam logic [15:0] A_EN       = 16'h0040;
  localparam logic [15:0] B_LOAD     = 16'h0020;
  localparam logic [15:0] ALU_SUB    = 16'h0010;
  localparam logic [15:0] ALU_EN     = 16'h0008;
  localparam logic [15:0] OUT_LOAD   = 16'h0004;
  localparam logic [15:0] FLAGS_LOAD = 16'h0002;
  localparam logic [15:0] RAM_WE     = 16'h0001;

  logic [2:0] stage_q, stage_d;
  logic       halted_q, halted_d;
  logic       step_q;
  logic [2:0] last_stage;
  logic       at_last;
  logic       adv;

  always_comb begin
    last_stage = T2;
    unique case (opcode)
      OP_LDA, OP_STA:                                 last_stage = T4;
      OP_ADD, OP_SUB:                                 last_stage = T5;
      OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT:   last_stage = T3;
      default:                                        last_stage = T2;
    endcase
  end

  assign at_last = VARIABLE_LEN ? (stage_q == last_stage) : (stage_q == T5);

  // A held step only counts on its rising edge; run and a step edge together still advance once.
  assign adv = STEP_EN ? (run | (step & ~step_q)) : 1'b1;

  always_comb begin
    stage_d  = stage_q;
    halted_d = halted_q;
    if (adv && !halted_q) begin
      if (stage_q == T3 && opcode == OP_HLT) begin
        halted_d = 1'b1;
      end else if (at_last) begin
        stage_d = T0;
      end else begin
        stage_d = stage_q + 3'd1;
      end
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      stage_q  <= T0;
      halted_q <= 1'b0;
      step_q   <= 1'b0;
    end else begin
      stage_q  <= stage_d;
      halted_q <= halted_d;
      step_q   <= step;
    end
  end

  // Stages beyond an opcode's last active stage decode to zero, which gives legacy padding.
  always_comb begin
    out = 16'h0000;
    if (halted_q) begin
      out = HLT;
    end else begin
      unique case (stage_q)
        T0: out = PC_EN | MEM_LOAD;
        T1: out = MEM_EN | IR_LOAD;
        T2: out = PC_INC;
        T3: begin
          unique case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: out = IR_EN | MEM_LOAD;
            OP_LDI:                         out = IR_EN | A_LOAD;
            OP_JMP:                         out = IR_EN | PC_LOAD;
            OP_JC:                          out = IR_EN | (carry ? PC_LOAD : 16'h0000);
            OP_JZ:                          out = IR_EN | (zero ? PC_LOAD : 16'h0000);
            OP_OUT:                         out = A_EN | OUT_LOAD;
            OP_HLT:                         out = HLT;
            default:                        out = 16'h0000;
          endcase
        end
        T4: begin
          unique case (opcode)
            OP_LDA:         out = MEM_EN | A_LOAD;
            OP_ADD, OP_SUB: out = MEM_EN | B_LOAD;
            OP_STA:         out = A_EN | RAM_WE;
            default:        out = 16'h0000;
          endcase
        end
        T5: begin
          unique case (opcode)
            OP_ADD:  out = ALU_EN | A_LOAD | FLAGS_LOAD;
            OP_SUB:  out = ALU_EN | A_LOAD | FLAGS_LOAD | ALU_SUB;
            default: out = 16'h0000;
          endcase
        end
        default: out = 16'h0000;
      endcase
    end
  end

  assign stage     = stage_q;
  assign halted    = halted_q;
  assign instr_end = at_last & ~halted_q;

endmodule

// File: tb/tb_sap_microsequencer.sv
// Directed bench for sap_microsequencer: variable-length/stepped instance plus a legacy
// fixed-length free-running instance.
module tb_sap_microsequencer;

  logic        clk = 1'b0;
  logic        rst, rst_f;
  logic [3:0]  opcode, opcode_f;
  logic        carry, zero, run, step;
  logic [15:0] out, out_f;
  logic [2:0]  stage, stage_f;
  logic        halted, halted_f, instr_end, instr_end_f;

  int errors = 0;
  int checks = 0;

  sap_microsequencer #(.VARIABLE_LEN(1'b1), .STEP_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .carry(carry), .zero(zero), .run(run),
    .step(step), .out(out), .stage(stage), .halted(halted), .instr_end(instr_end)
  );

  sap_microsequencer #(.VARIABLE_LEN(1'b0), .STEP_EN(1'b0)) dut_fixed (
    .clk(clk), .rst(rst_f), .opcode(opcode_f), .carry(carry), .zero(zero), .run(run),
    .step(step), .out(out_f), .stage(stage_f), .halted(halted_f), .instr_end(instr_end_f)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic        c;
    logic        z;
    logic [2:0]  st;
    logic [15:0] cw;
    logic        fin;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Push one row per stage of an instruction; fetch words are common to every opcode.
  task automatic add_instr(input logic [3:0] op, input logic c, input logic z, input int last,
                           input logic [15:0] w3, input logic [15:0] w4, input logic [15:0] w5);
    for (int s = 0; s <= last; s++) begin
      vec_t v;
      v.op  = op;
      v.c   = c;
      v.z   = z;
      v.st  = 3'(s);
      v.cw  = (s == 0) ? 16'h2800 : (s == 1) ? 16'h0600 : (s == 2) ? 16'h4000 :
              (s == 3) ? w3 : (s == 4) ? w4 : w5;
      v.fin = (s == last);
      vecs.push_back(v);
    end
  endtask

  initial begin
    logic [15:0] ldi_exp [6];
    logic [15:0] nop_exp [6];
    ldi_exp = '{16'h2800, 16'h0600, 16'h4000, 16'h0180, 16'h0000, 16'h0000};
    nop_exp = '{16'h2800, 16'h0600, 16'h4000, 16'h0000, 16'h0000, 16'h0000};

    add_instr(4'b0000, 1'b0, 1'b0, 4, 16'h0900, 16'h0480, 16'h0000); // LDA
    add_instr(4'b0001, 1'b0, 1'b0, 5, 16'h0900, 16'h0420, 16'h008A); // ADD
    add_instr(4'b0010, 1'b0, 1'b0, 5, 16'h0900, 16'h0420, 16'h009A); // SUB
    add_instr(4'b0011, 1'b0, 1'b0, 4, 16'h0900, 16'h0041, 16'h0000); // STA
    add_instr(4'b0100, 1'b0, 1'b0, 3, 16'h0180, 16'h0000, 16'h0000); // LDI
    add_instr(4'b0101, 1'b0, 1'b0, 3, 16'h1100, 16'h0000, 16'h0000); // JMP
    add_instr(4'b0110, 1'b0, 1'b0, 3, 16'h0100, 16'h0000, 16'h0000); // JC, no carry
    add_instr(4'b0110, 1'b1, 1'b0, 3, 16'h1100, 16'h0000, 16'h0000); // JC, carry
    add_instr(4'b0111, 1'b0, 1'b1, 3, 16'h1100, 16'h0000, 16'h0000); // JZ, zero
    add_instr(4'b0111, 1'b1, 1'b0, 3, 16'h0100, 16'h0000, 16'h0000); // JZ, not zero
    add_instr(4'b1110, 1'b0, 1'b0, 3, 16'h0044, 16'h0000, 16'h0000); // OUT
    add_instr(4'b1000, 1'b0, 1'b0, 2, 16'h0000, 16'h0000, 16'h0000); // NOP

    rst = 1'b0; rst_f = 1'b0;
    opcode = 4'b0000; opcode_f = 4'b0100;
    carry = 1'b0; zero = 1'b0; run = 1'b1; step = 1'b0;
    #1;
    rst = 1'b1; rst_f = 1'b1;
    #1;
    check("reset stage", 16'(stage), 16'd0);
    check("reset out", out, 16'h2800);
    check("reset halted", 16'(halted), 16'd0);
    check("reset instr_end", 16'(instr_end), 16'd0);
    @(negedge clk);
    #1 rst = 1'b0;

    // Free-run through every opcode, one row per negedge.
    foreach (vecs[i]) begin
      opcode = vecs[i].op;
      carry  = vecs[i].c;
      zero   = vecs[i].z;
      #1;
      check($sformatf("vec%0d stage", i), 16'(stage), 16'(vecs[i].st));
      check($sformatf("vec%0d out", i), out, vecs[i].cw);
      check($sformatf("vec%0d instr_end", i), 16'(instr_end), 16'(vecs[i].fin));
      tick();
    end
    check("table wrap stage", 16'(stage), 16'd0);

    // Asynchronous reset in the middle of ADD, between clock edges.
    opcode = 4'b0001; carry = 1'b0; zero = 1'b0;
    repeat (4) tick();
    check("add pre-reset stage", 16'(stage), 16'd4);
    #2 rst = 1'b1;
    #1;
    check("midreset stage", 16'(stage), 16'd0);
    check("midreset out", out, 16'h2800);
    check("midreset halted", 16'(halted), 16'd0);
    check("midreset instr_end", 16'(instr_end), 16'd0);
    @(negedge clk);
    #1 rst = 1'b0;

    // Sticky halt.
    opcode = 4'b1111;
    repeat (3) tick();
    check("hlt t3 stage", 16'(stage), 16'd3);
    check("hlt t3 out", out, 16'h8000);
    check("hlt t3 halted", 16'(halted), 16'd0);
    tick();
    check("halt stage", 16'(stage), 16'd3);
    check("halt flag", 16'(halted), 16'd1);
    check("halt out", out, 16'h8000);
    for (int k = 0; k < 10; k++) begin
      step = ~step;
      tick();
      check($sformatf("halted%0d stage", k), 16'(stage), 16'd3);
      check($sformatf("halted%0d out", k), out, 16'h8000);
      check($sformatf("halted%0d flag", k), 16'(halted), 16'd1);
    end
    step = 1'b0;
    rst = 1'b1;
    #1;
    check("unhalt stage", 16'(stage), 16'd0);
    check("unhalt flag", 16'(halted), 16'd0);
    tick();
    rst = 1'b0;

    // Single-step gating.
    opcode = 4'b0000; run = 1'b0;
    tick();
    check("idle no advance", 16'(stage), 16'd0);
    step = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("step held%0d stage", k), 16'(stage), 16'd1);
    end
    step = 1'b0;
    tick();
    check("step low stage", 16'(stage), 16'd1);
    step = 1'b1;
    tick();
    check("step rearm stage", 16'(stage), 16'd2);
    step = 1'b0;
    tick();
    check("step idle stage", 16'(stage), 16'd2);
    run = 1'b1; step = 1'b1;
    tick();
    check("run+step single advance", 16'(stage), 16'd3);
    run = 1'b0;
    tick();
    check("run off step held", 16'(stage), 16'd3);
    run = 1'b1; step = 1'b0;

    // Legacy fixed-length timing on the second instance.
    opcode_f = 4'b0100;
    @(negedge clk);
    #1 rst_f = 1'b0;
    for (int s = 0; s < 6; s++) begin
      #1;
      check($sformatf("fixed ldi t%0d stage", s), 16'(stage_f), 16'(s));
      check($sformatf("fixed ldi t%0d out", s), out_f, ldi_exp[s]);
      check($sformatf("fixed ldi t%0d instr_end", s), 16'(instr_end_f), 16'(s == 5));
      tick();
    end
    check("fixed ldi wrap", 16'(stage_f), 16'd0);
    opcode_f = 4'b1010;
    for (int s = 0; s < 6; s++) begin
      #1;
      check($sformatf("fixed nop t%0d stage", s), 16'(stage_f), 16'(s));
      check($sformatf("fixed nop t%0d out", s), out_f, nop_exp[s]);
      check($sformatf("fixed nop t%0d instr_end", s), 16'(instr_end_f), 16'(s == 5));
      tick();
    end
    check("fixed nop wrap", 16'(stage_f), 16'd0);
    check("fixed halted", 16'(halted_f), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
